predict_pc_freg: RTL and testbench
==================================

// Module: predict_pc_freg
// PURPOSE
//   Producer side of the fetch-PC path: owns the F pipeline register (F_predPC)
//   and computes the next predicted PC from the instruction just fetched.
//   Branch policy: always-taken for jXX; call -> valC; everything else -> valP.
//   The PC selector downstream corrects this prediction from M (not-taken jXX)
//   and W (ret). Also keeps saturating prediction/perf counters for the core.
// PARAMETERS
//   RESET_PC   64'h0  value loaded into F_predPC on reset
//   CNT_W      32     width of each perf counter (1..64)
// PORTS
//   clk_i          in   1   core clock; all state updates on rising edge
//   rst_i          in   1   synchronous reset, active-high
//   F_stall_i      in   1   hold F register (from pipeline control)
//   f_icode_i      in   4   icode of instruction fetched this cycle
//   f_valC_i       in   64  constant word of fetched instruction
//   f_valP_i       in   64  address of next sequential instruction
//   M_icode_i      in   4   icode in M stage
//   M_Cnd_i        in   1   branch condition resolved in M stage
//   W_icode_i      in   4   icode in W stage
//   cnt_clr_i      in   1   synchronous clear of all perf counters
//   F_predPC_o     out  64  registered predicted PC (to PC select)
//   f_predPC_o     out  64  combinational next prediction (debug/trace)
//   cnt_jxx_o      out  CNT_W  jXX instructions accepted into F->D
//   cnt_call_o     out  CNT_W  call instructions accepted into F->D
//   cnt_mispred_o  out  CNT_W  jXX mispredictions resolved in M
//   cnt_ret_o      out  CNT_W  ret instructions reaching W
//   cnt_stall_o    out  CNT_W  cycles with F_stall_i high
// BEHAVIOUR
//   Prediction (combinational): f_predPC_o = f_valC_i if f_icode_i is IJXX or
//     ICALL, else f_valP_i. No other icode (incl. IRET, IHALT, invalid) alters this.
//   F register: on rst_i, F_predPC_o <= RESET_PC. Else if F_stall_i, hold.
//     Else F_predPC_o <= f_predPC_o. Latency: 1 cycle from fetch to F_predPC_o.
//   No bubble input: F is never bubbled; stall has priority over load.
//   "Accepted" = cycle where !rst_i && !F_stall_i.
//   Counters (all CNT_W bits, unsigned, saturate at 2^CNT_W-1, never wrap):
//     cnt_jxx   +1 when accepted && f_icode_i==IJXX
//     cnt_call  +1 when accepted && f_icode_i==ICALL
//     cnt_mispred +1 when M_icode_i==IJXX && !M_Cnd_i (independent of stall;
//       M is bubbled, never stalled, so each instruction counts once)
//     cnt_ret   +1 when W_icode_i==IRET (independent of stall)
//     cnt_stall +1 when F_stall_i
//   Several counters may increment in the same cycle; each independent.
//   Reset: all counters -> 0, F_predPC_o -> RESET_PC; reset mid-stall wins.
//   cnt_clr_i: all counters -> 0 that cycle (increments in that cycle dropped);
//     F register unaffected. rst_i overrides cnt_clr_i (same result).
//   Outputs are direct register values; no combinational path from inputs to
//     F_predPC_o or cnt_*_o.
//   f_valC_i/f_valP_i are 64-bit; no truncation or sign handling; address
//     wrap-around in valP is the fetch unit's concern, passed through as-is.
// TESTING
//   1. Reset RESET_PC=64'h100: rst_i 1 cycle -> F_predPC_o=64'h100, all cnt=0.
//   2. f_icode=IJXX, valC=64'h40, valP=64'h29, no stall -> next cycle
//      F_predPC_o=64'h40, cnt_jxx=1; f_icode=IIRMOVQ valP=64'h33 -> 64'h33.
//   3. F_stall_i high 3 cycles with changing f_valP -> F_predPC_o held,
//      cnt_stall=3, cnt_jxx/cnt_call unchanged even if f_icode=IJXX/ICALL.
//   4. M_icode=IJXX,M_Cnd=0 for 2 cycles; W_icode=IRET same cycles ->
//      cnt_mispred=2, cnt_ret=2; M_Cnd=1 -> no mispred count.
//   5. CNT_W=4: 20 ICALL fetches -> cnt_call sticks at 15; cnt_clr_i -> 0 next
//      cycle while F_predPC_o keeps tracking valC.
//   6. rst_i asserted during stall with counters nonzero -> F_predPC_o=RESET_PC,
//      all counters 0 on the following cycle.

Source files
------------

// File: rtl/predict_pc_freg.sv
// ----------------------------------------------------------------------------
// predict_pc_freg
//   Producer side of the fetch-PC path. Holds the F pipeline register
//   (F_predPC) and predicts the next PC from the instruction just fetched:
//   jXX and call predict valC (jXX always-taken), everything else valP.
//   Mispredicted jXX (resolved in M) and ret (resolved in W) are corrected
//   downstream by the PC selector; this block only counts them.
//   Also keeps five saturating performance counters.
//
// Ports
//   clk_i          core clock, all state updates on rising edge
//   rst_i          synchronous active-high reset
//   F_stall_i      hold the F register
//   f_icode_i      icode of the instruction fetched this cycle
//   f_valC_i       constant word of the fetched instruction
//   f_valP_i       address of the next sequential instruction
//   M_icode_i      icode in M stage
//   M_Cnd_i        branch condition resolved in M stage
//   W_icode_i      icode in W stage
//   cnt_clr_i      synchronous clear of all perf counters
//   F_predPC_o     registered predicted PC
//   f_predPC_o     combinational next prediction (debug/trace)
//   cnt_jxx_o      jXX instructions accepted into F->D
//   cnt_call_o     call instructions accepted into F->D
//   cnt_mispred_o  jXX mispredictions resolved in M
//   cnt_ret_o      ret instructions reaching W
//   cnt_stall_o    cycles with F_stall_i high
// ----------------------------------------------------------------------------
module predict_pc_freg #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             F_stall_i,
   input  logic [3:0]       f_icode_i,
   input  logic [63:0]      f_valC_i,
   input  logic [63:0]      f_valP_i,
   input  logic [3:0]       M_icode_i,
   input  logic             M_Cnd_i,
   input  logic [3:0]       W_icode_i,
   input  logic             cnt_clr_i,
   output logic [63:0]      F_predPC_o,
   output logic [63:0]      f_predPC_o,
   output logic [CNT_W-1:0] cnt_jxx_o,
   output logic [CNT_W-1:0] cnt_call_o,
   output logic [CNT_W-1:0] cnt_mispred_o,
   output logic [CNT_W-1:0] cnt_ret_o,
   output logic [CNT_W-1:0] cnt_stall_o
);

   localparam logic [3:0]       IJXX    = 4'h7;
   localparam logic [3:0]       ICALL   = 4'h8;
   localparam logic [3:0]       IRET    = 4'h9;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [63:0]      predpc_q, predpc_d;
   logic [CNT_W-1:0] jxx_q, jxx_d;
   logic [CNT_W-1:0] call_q, call_d;
   logic [CNT_W-1:0] mispred_q, mispred_d;
   logic [CNT_W-1:0] ret_q, ret_d;
   logic [CNT_W-1:0] stall_q, stall_d;

   logic inc_jxx, inc_call, inc_mispred, inc_ret, inc_stall;

   // Saturating increment: holds at all-ones instead of wrapping
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   // Next-PC prediction: always-taken jXX, call target, else fall-through
   always_comb begin
      f_predPC_o = f_valP_i;
      if ((f_icode_i == IJXX) || (f_icode_i == ICALL)) begin
         f_predPC_o = f_valC_i;
      end
   end

   // Event decode; jXX/call count only when accepted (not stalled)
   always_comb begin
      inc_jxx     = !F_stall_i && (f_icode_i == IJXX);
      inc_call    = !F_stall_i && (f_icode_i == ICALL);
      inc_mispred = (M_icode_i == IJXX) && !M_Cnd_i;
      inc_ret     = (W_icode_i == IRET);
      inc_stall   = F_stall_i;
   end

   // Next-state for F register and counters; clear drops same-cycle increments
   always_comb begin
      predpc_d  = predpc_q;
      jxx_d     = jxx_q;
      call_d    = call_q;
      mispred_d = mispred_q;
      ret_d     = ret_q;
      stall_d   = stall_q;

      if (!F_stall_i) begin
         predpc_d = f_predPC_o;
      end

      if (cnt_clr_i) begin
         jxx_d     = '0;
         call_d    = '0;
         mispred_d = '0;
         ret_d     = '0;
         stall_d   = '0;
      end else begin
         if (inc_jxx)     jxx_d     = sat_inc(jxx_q);
         if (inc_call)    call_d    = sat_inc(call_q);
         if (inc_mispred) mispred_d = sat_inc(mispred_q);
         if (inc_ret)     ret_d     = sat_inc(ret_q);
         if (inc_stall)   stall_d   = sat_inc(stall_q);
      end
   end

   // State registers; reset overrides stall and clear
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         predpc_q  <= RESET_PC;
         jxx_q     <= '0;
         call_q    <= '0;
         mispred_q <= '0;
         ret_q     <= '0;
         stall_q   <= '0;
      end else begin
         predpc_q  <= predpc_d;
         jxx_q     <= jxx_d;
         call_q    <= call_d;
         mispred_q <= mispred_d;
         ret_q     <= ret_d;
         stall_q   <= stall_d;
      end
   end

   assign F_predPC_o    = predpc_q;
   assign cnt_jxx_o     = jxx_q;
   assign cnt_call_o    = call_q;
   assign cnt_mispred_o = mispred_q;
   assign cnt_ret_o     = ret_q;
   assign cnt_stall_o   = stall_q;

endmodule

// File: tb/tb_predict_pc_freg.sv
// ----------------------------------------------------------------------------
// tb_predict_pc_freg
//   Directed bench for predict_pc_freg. Two instances share all inputs:
//   one with 32-bit counters and one with 4-bit counters (saturation).
//   A reference model computes the expected register state for each driven
//   cycle and pushes it to a scoreboard queue; it is popped and compared
//   after the next rising edge.
// ----------------------------------------------------------------------------
module tb_predict_pc_freg;

   localparam logic [63:0] RPC = 64'h100;
   localparam logic [3:0] IHALT = 4'h0, INOP = 4'h1, IIRMOVQ = 4'h3, IOPQ = 4'h6;
   localparam logic [3:0] IJXX = 4'h7, ICALL = 4'h8, IRET = 4'h9, IBAD = 4'hF;

   typedef struct packed {
      logic [63:0]      pc;
      logic [4:0][31:0] c32;
      logic [4:0][3:0]  c4;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, stall, mcnd, clr;
   logic [3:0]  fic, mic, wic;
   logic [63:0] valc, valp;

   logic [63:0] pc_a, pred_a, pc_b, pred_b;
   logic [31:0] jxx_a, call_a, misp_a, ret_a, stl_a;
   logic [3:0]  jxx_b, call_b, misp_b, ret_b, stl_b;

   int n_assert = 0;
   int n_fail   = 0;

   exp_t        sb[$];
   logic [63:0] m_pc;
   logic [31:0] m32[5];
   logic [3:0]  m4[5];

   predict_pc_freg #(.RESET_PC(RPC), .CNT_W(32)) dut_a (
      .clk_i(clk), .rst_i(rst), .F_stall_i(stall), .f_icode_i(fic),
      .f_valC_i(valc), .f_valP_i(valp), .M_icode_i(mic), .M_Cnd_i(mcnd),
      .W_icode_i(wic), .cnt_clr_i(clr), .F_predPC_o(pc_a), .f_predPC_o(pred_a),
      .cnt_jxx_o(jxx_a), .cnt_call_o(call_a), .cnt_mispred_o(misp_a),
      .cnt_ret_o(ret_a), .cnt_stall_o(stl_a));

   predict_pc_freg #(.RESET_PC(RPC), .CNT_W(4)) dut_b (
      .clk_i(clk), .rst_i(rst), .F_stall_i(stall), .f_icode_i(fic),
      .f_valC_i(valc), .f_valP_i(valp), .M_icode_i(mic), .M_Cnd_i(mcnd),
      .W_icode_i(wic), .cnt_clr_i(clr), .F_predPC_o(pc_b), .f_predPC_o(pred_b),
      .cnt_jxx_o(jxx_b), .cnt_call_o(call_b), .cnt_mispred_o(misp_b),
      .cnt_ret_o(ret_b), .cnt_stall_o(stl_b));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, check the combinational prediction, push expected state
   task automatic step(input logic r, input logic s, input logic [3:0] fi,
                       input logic [63:0] vc, input logic [63:0] vp,
                       input logic [3:0] mi, input logic mc, input logic [3:0] wi,
                       input logic c);
      logic [4:0]  inc;
      logic [63:0] pred;
      exp_t        e;
      rst = r; stall = s; fic = fi; valc = vc; valp = vp;
      mic = mi; mcnd = mc; wic = wi; clr = c;
      pred = ((fi == IJXX) || (fi == ICALL)) ? vc : vp;
      #1;
      chk("f_predPC_a", pred_a, pred);
      chk("f_predPC_b", pred_b, pred);
      inc[0] = !s && (fi == IJXX);
      inc[1] = !s && (fi == ICALL);
      inc[2] = (mi == IJXX) && !mc;
      inc[3] = (wi == IRET);
      inc[4] = s;
      if (r) begin
         m_pc = RPC;
         for (int i = 0; i < 5; i++) begin m32[i] = '0; m4[i] = '0; end
      end else begin
         if (!s) m_pc = pred;
         for (int i = 0; i < 5; i++) begin
            if (c) begin
               m32[i] = '0; m4[i] = '0;
            end else if (inc[i]) begin
               if (m32[i] != 32'hFFFF_FFFF) m32[i] = m32[i] + 32'd1;
               if (m4[i] != 4'hF) m4[i] = m4[i] + 4'd1;
            end
         end
      end
      e.pc = m_pc;
      for (int i = 0; i < 5; i++) begin e.c32[i] = m32[i]; e.c4[i] = m4[i]; end
      sb.push_back(e);
      @(posedge clk);
      #1;
      compare();
   endtask

   task automatic compare();
      exp_t        e;
      logic [31:0] o32[5];
      logic [3:0]  o4[5];
      n_assert++;
      assert (sb.size() != 0) else begin
         n_fail++;
         $error("FAIL scoreboard_empty: observed %0d expected >0", sb.size());
         return;
      end
      e = sb.pop_front();
      o32[0] = jxx_a; o32[1] = call_a; o32[2] = misp_a; o32[3] = ret_a; o32[4] = stl_a;
      o4[0]  = jxx_b; o4[1]  = call_b; o4[2]  = misp_b; o4[3]  = ret_b; o4[4]  = stl_b;
      chk("F_predPC_a", pc_a, e.pc);
      chk("F_predPC_b", pc_b, e.pc);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("cnt32[%0d]", i), 64'(o32[i]), 64'(e.c32[i]));
         chk($sformatf("cnt4[%0d]", i), 64'(o4[i]), 64'(e.c4[i]));
      end
   endtask

   initial begin
      #200000;
      $error("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #2;
      // Reset
      step(1, 0, INOP, 64'h0, 64'h0, INOP, 1, INOP, 0);
      chk("reset_pc", pc_a, 64'h100);
      chk("reset_jxx", 64'(jxx_a), 64'h0);

      // Taken-predicted jXX, then sequential instruction
      step(0, 0, IJXX, 64'h40, 64'h29, INOP, 1, INOP, 0);
      chk("jxx_pc", pc_a, 64'h40);
      chk("jxx_cnt", 64'(jxx_a), 64'd1);
      step(0, 0, IIRMOVQ, 64'h1234, 64'h33, INOP, 1, INOP, 0);
      chk("irmovq_pc", pc_a, 64'h33);

      // Other icodes fall through to valP, including ret/halt/invalid
      step(0, 0, IRET, 64'hDEAD, 64'h50, INOP, 1, INOP, 0);
      step(0, 0, IHALT, 64'hBEEF, 64'h60, INOP, 1, INOP, 0);
      step(0, 0, IBAD, 64'hCAFE, 64'h70, INOP, 1, INOP, 0);
      step(0, 0, IOPQ, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, INOP, 1, INOP, 0);
      step(0, 0, ICALL, 64'h8000_0000_0000_0010, 64'h2, INOP, 1, INOP, 0);
      step(0, 0, IIRMOVQ, 64'h0, 64'h33, INOP, 1, INOP, 0);

      // Stall 3 cycles: hold PC, no jxx/call counts
      step(0, 1, IJXX, 64'h400, 64'h90, INOP, 1, INOP, 0);
      step(0, 1, ICALL, 64'h500, 64'h91, INOP, 1, INOP, 0);
      step(0, 1, IJXX, 64'h600, 64'h92, INOP, 1, INOP, 0);
      chk("stall_hold_pc", pc_a, 64'h33);
      chk("stall_cnt", 64'(stl_a), 64'd3);

      // Mispredicts and rets, then a correctly predicted jXX in M
      step(0, 0, INOP, 64'h0, 64'hA0, IJXX, 0, IRET, 0);
      step(0, 0, INOP, 64'h0, 64'hA8, IJXX, 0, IRET, 0);
      step(0, 0, INOP, 64'h0, 64'hB0, IJXX, 1, INOP, 0);
      chk("mispred_cnt", 64'(misp_a), 64'd2);
      chk("ret_cnt", 64'(ret_a), 64'd2);
      // Mispredict and ret still count while F is stalled
      step(0, 1, IJXX, 64'h0, 64'hB8, IJXX, 0, IRET, 0);

      // Saturation: 20 calls, 4-bit counter sticks at 15
      for (int k = 0; k < 20; k++)
         step(0, 0, ICALL, 64'h1000 + 64'(k * 8), 64'h9, INOP, 1, INOP, 0);
      chk("call_sat4", 64'(call_b), 64'd15);

      // Clear with simultaneous events: counters zero, PC keeps tracking valC
      step(0, 0, ICALL, 64'h2000, 64'h9, IJXX, 0, IRET, 1);
      chk("clr_call", 64'(call_b), 64'd0);
      chk("clr_pc", pc_a, 64'h2000);
      step(0, 0, ICALL, 64'h3000, 64'h9, INOP, 1, INOP, 0);
      step(0, 1, IJXX, 64'h0, 64'h9, IJXX, 0, IRET, 0);

      // Reset during stall with nonzero counters
      step(1, 1, IJXX, 64'h7777, 64'h8888, IJXX, 0, IRET, 0);
      chk("rst_stall_pc", pc_a, 64'h100);
      // Reset together with clear
      step(0, 0, IJXX, 64'h44, 64'h8, IJXX, 0, IRET, 0);
      step(1, 0, IJXX, 64'h55, 64'h8, IJXX, 0, IRET, 1);
      step(0, 0, INOP, 64'h0, 64'h10, INOP, 1, INOP, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
